tag_stage_skid_reg: RTL and testbench

//   Parametrised pipeline stage register for the multibit-tree tag sorter.

---
 rtl/tag_stage_skid_reg_if.sv | 23 ++
 rtl/tag_stage_skid_reg.sv | 132 +++++++++++++
 tb/tb_tag_stage_skid_reg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tag_stage_skid_reg_if.sv
// ---------------------------------------------------------------------------
// tag_stage_skid_reg_if
//   Valid/ready/data handshake bundle between two tag-sorter tree stages.
//   Parameters:
//     W      width of the data bundle in bits
//   Signals:
//     valid  producer -> consumer, data holds a valid bundle
//     ready  consumer -> producer, consumer accepts data this cycle
//     data   W-bit tag bundle
//   Modports:
//     master producer side (drives valid/data, samples ready)
//     slave  consumer side (samples valid/data, drives ready)
// ---------------------------------------------------------------------------
interface tag_stage_skid_reg_if #(
  parameter int W = 24
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/tag_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// tag_stage_skid_reg
//   Pipeline stage register for the multibit-tree tag sorter. Carries
//   N_FIELDS opaque tag fields between tree stages with a valid/ready
//   handshake, an optional 2-entry skid buffer and a synchronous flush.
//   Parameters:
//     TAG_W     width of one tag field
//     N_FIELDS  number of fields per bundle (field k = [k*TAG_W +: TAG_W])
//     SKID_EN   1: main + skid register, in_ready decoded from state
//               0: main register only, in_ready = !out_valid | out_ready
//   Ports:
//     clk          clock
//     rst          synchronous active-high reset
//     flush_i      synchronous flush, discards every held bundle
//     in_if        upstream handshake (slave)
//     out_if       downstream handshake (master); data is 0 when not valid
//     occupancy_o  bundles held: 0, 1 or 2
// ---------------------------------------------------------------------------
module tag_stage_skid_reg #(
  parameter int TAG_W    = 12,
  parameter int N_FIELDS = 2,
  parameter int SKID_EN  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  tag_stage_skid_reg_if.slave  in_if,
  tag_stage_skid_reg_if.master out_if,
  output logic [1:0]           occupancy_o
);

  localparam int W = TAG_W * N_FIELDS;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q;
  logic           out_valid;
  logic           in_ready;
  logic           accept;
  logic           fire;

  assign out_valid = (state_q != EMPTY);
  assign fire      = out_valid & out_if.ready;
  assign accept    = in_if.valid & in_ready;

  generate
    if (SKID_EN != 0) begin : g_skid
      // Ready depends only on held state (plus reset gating), so there is
      // no combinational path from out_ready back to in_ready.
      assign in_ready = !rst && (state_q != TWO);

      // Skid entry captures the bundle that arrives while main is stalled.
      always_ff @(posedge clk) begin
        if (rst || flush_i) begin
          skid_q <= '0;
        end else if ((state_q == ONE) && accept && !fire) begin
          skid_q <= in_if.data;
        end
      end
    end else begin : g_noskid
      // Single register: accept whenever main is empty or draining now.
      assign in_ready = !rst && (!out_valid || out_if.ready);
      assign skid_q   = '0;
    end
  endgenerate

  // Next-state and main-register load.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_if.data;
        end
      end
      ONE: begin
        if (accept && fire) begin
          main_d = in_if.data;
        end else if (accept) begin
          // Only reachable with a skid entry; without one in_ready already
          // blocks accept while main is stalled.
          if (SKID_EN != 0) begin
            state_d = TWO;
          end
        end else if (fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush wins over any transfer in the same cycle, including a
    // concurrent accept.
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_valid ? main_q : '0;
  assign occupancy_o  = state_q;

endmodule

// File: tb/tb_tag_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_tag_stage_skid_reg
//   Runs a SKID_EN=0 and a SKID_EN=1 instance side by side on shared
//   stimulus. Each instance has its own FIFO scoreboard: bundles are pushed
//   on accept and the head must be what the stage presents. Queue depth
//   gives the expected occupancy, out_valid and in_ready.
// ---------------------------------------------------------------------------
module tb_tag_stage_skid_reg;

  localparam int TAG_W = 12;
  localparam int NF    = 3;
  localparam int W     = TAG_W * NF;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  bit           verbose = 1'b1;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam bit SKID = (gi == 1);

    tag_stage_skid_reg_if #(.W(W)) in_if ();
    tag_stage_skid_reg_if #(.W(W)) out_if ();
    logic [1:0]   occ;
    logic [W-1:0] q[$];
    logic         stall_q = 1'b0;
    logic [W-1:0] held_q  = '0;

    assign in_if.valid  = in_valid;
    assign in_if.data   = in_data;
    assign out_if.ready = out_ready;

    tag_stage_skid_reg #(
      .TAG_W   (TAG_W),
      .N_FIELDS(NF),
      .SKID_EN (gi)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush),
      .in_if      (in_if.slave),
      .out_if     (out_if.master),
      .occupancy_o(occ)
    );

    always @(negedge clk) begin
      logic         exp_ready;
      logic [W-1:0] exp_data;
      if (SKID) exp_ready = !rst && (q.size() < 2);
      else      exp_ready = !rst && ((q.size() == 0) || out_ready);
      exp_data = (q.size() != 0) ? q[0] : '0;

      chk($sformatf("s%0d.in_ready", gi), 48'(in_if.ready), 48'(exp_ready));
      chk($sformatf("s%0d.out_valid", gi), 48'(out_if.valid), 48'(q.size() != 0));
      chk($sformatf("s%0d.out_data", gi), 48'(out_if.data), 48'(exp_data));
      chk($sformatf("s%0d.occupancy", gi), 48'(occ), 48'(q.size()));
      if (stall_q) begin
        chk($sformatf("s%0d.stable", gi), 48'(out_if.data), 48'(held_q));
      end

      if (out_if.valid && out_ready) begin
        if (verbose) $display("[s%0d] t=%0t out %h", gi, $time, out_if.data);
        if (q.size() != 0) void'(q.pop_front());
      end
      if (rst || flush) q.delete();
      else if (in_valid && in_if.ready) q.push_back(in_data);

      stall_q <= out_if.valid && !out_ready && !rst && !flush;
      held_q  <= out_if.data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] stream [3];

  initial begin
    stream[0] = {12'h000, 12'h0A1, 12'h0B1};
    stream[1] = {12'h000, 12'h0A2, 12'h0B2};
    stream[2] = {12'h000, 12'h0A3, 12'h0B3};

    // Reset with in_valid high.
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = stream[0]; out_ready = 1'b0;
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst.in_ready1", 48'(g_dut[1].in_if.ready), 48'(1));
    chk("rst.in_ready0", 48'(g_dut[0].in_if.ready), 48'(1));
    step();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = stream[i];
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Stall: three offers against a blocked consumer.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = {12'h000, 12'h0C1, 12'h0D1}; step();
    in_data = {12'h000, 12'h0C2, 12'h0D2}; step();
    in_data = {12'h000, 12'h0C3, 12'h0D3};
    @(negedge clk);
    chk("stall.occ", 48'(g_dut[1].occ), 48'(2));
    chk("stall.in_ready", 48'(g_dut[1].in_if.ready), 48'(0));
    step();
    out_ready = 1'b1;
    step(); step();
    in_valid = 1'b0;
    repeat (3) step();

    // Flush while full, with a concurrent offer.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = {12'h000, 12'h0E1, 12'h0F1}; step();
    in_data = {12'h000, 12'h0E2, 12'h0F2}; step();
    in_data = {12'h000, 12'h0E3, 12'h0F3}; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush.valid", 48'(g_dut[1].out_if.valid), 48'(0));
    chk("flush.occ", 48'(g_dut[1].occ), 48'(0));
    chk("flush.data", 48'(g_dut[1].out_if.data), 48'(0));
    out_ready = 1'b1;
    repeat (3) step();

    // Toggling out_ready with continuous offers.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 2 == 0);
      in_data   = {12'h000, 12'h100 + 12'(i), 12'h200 + 12'(i)};
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    // Random valid/ready with occasional flush.
    verbose = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      in_data   = {4'($urandom), 32'($urandom)};
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
